// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple-dual-port RAM.
// Holds the INIT/RUN state type, latency bounds and byte parity.
package ram_pkg;

  localparam int BYTE_W     = 8;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  typedef enum logic {
    INIT,
    RUN
  } ram_state_e;

  // Even parity: the stored bit makes the lane's total one-count even.
  function automatic logic even_parity(
    input logic [BYTE_W-1:0] b
  );
    return ^b;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-side delay line: LAT register stages of valid plus payload.
// Ports: clk, rst_n, in_valid/in_data, out_valid/out_data (held when idle).
module ram_rd_pipe #(
  parameter int LAT = 1,
  parameter int W   = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [LAT-1:0] v_q;
  logic [W-1:0]   d_q [LAT];

  // Payload only moves with its valid, so the output holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < LAT; i++)
        d_q[i] <= '0;
    end else begin
      v_q[0] <= in_valid;
      if (in_valid)
        d_q[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1])
          d_q[i] <= d_q[i-1];
      end
    end
  end

  assign out_valid = v_q[LAT-1];
  assign out_data  = d_q[LAT-1];

endmodule

// File: rtl/ram_sdp.sv
// Simple-dual-port RAM: byte-enabled write port, write-first read port
// with RD_LAT 1/2, hardware clear after reset. RAM_PARITY_EN adds
// per-lane parity (rd_err, wr_err_inj).
module ram_sdp
  import ram_pkg::*;
#(
  parameter int DATA_WIDE    = 32,
  parameter int DEEP         = 512,
  parameter int ADDR_WIDE    = $clog2(DEEP),
  parameter int BE_WIDE      = DATA_WIDE / 8,
  parameter int RD_LAT       = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_WIDE-1:0] wr_addr,
  input  logic [DATA_WIDE-1:0] wr_data,
  input  logic [BE_WIDE-1:0]   wr_be,
  input  logic                 rd_valid,
  output logic                 rd_ready,
  input  logic [ADDR_WIDE-1:0] rd_addr,
  output logic                 rd_data_valid,
  output logic                 init_done,
`ifdef RAM_PARITY_EN
  output logic                 rd_err,
  input  logic                 wr_err_inj,
`endif
  output logic [DATA_WIDE-1:0] rd_data
);

  localparam int LAT =
    (RD_LAT >= RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;
  localparam int CW = $clog2(DEEP + 1);
`ifdef RAM_PARITY_EN
  localparam int PW = DATA_WIDE + 1;
`else
  localparam int PW = DATA_WIDE;
`endif

  ram_state_e state_q, state_d;
  logic [CW-1:0] clr_q, clr_d;
  logic clr_we;
  logic run, wr_fire, rd_fire, wr_in, rd_in;

  logic                 w_en;
  logic [ADDR_WIDE-1:0] w_addr;
  logic [DATA_WIDE-1:0] w_data;
  logic [BE_WIDE-1:0]   w_be;
  logic [DATA_WIDE-1:0] r_data;
  logic [PW-1:0]        p_in, p_out;

  logic [DATA_WIDE-1:0] mem [DEEP];

  assign run       = (state_q == RUN);
  assign wr_ready  = run;
  assign rd_ready  = run;
  assign init_done = run;
  assign wr_fire   = wr_valid & run;
  assign rd_fire   = rd_valid & run;
  assign wr_in     = int'(wr_addr) < DEEP;
  assign rd_in     = int'(rd_addr) < DEEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // The clear walks 0..DEEP-1; the cycle after the last word goes RUN.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    clr_we  = 1'b0;
    unique case (state_q)
      INIT: begin
        if (CLEAR_ON_RST == 0) begin
          state_d = RUN;
        end else if (clr_q == CW'(DEEP)) begin
          state_d = RUN;
        end else begin
          clr_we = 1'b1;
          clr_d  = clr_q + 1'b1;
        end
      end
      RUN: ;
      default: state_d = INIT;
    endcase
  end

  // One shared write port: clear words in INIT, user writes in RUN.
  always_comb begin
    w_en   = wr_fire & wr_in;
    w_addr = wr_addr;
    w_data = wr_data;
    w_be   = wr_be;
    if (clr_we) begin
      w_en   = 1'b1;
      w_addr = clr_q[ADDR_WIDE-1:0];
      w_data = '0;
      w_be   = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_en)
      for (int i = 0; i < BE_WIDE; i++)
        if (w_be[i])
          mem[w_addr][i*BYTE_W +: BYTE_W] <=
            w_data[i*BYTE_W +: BYTE_W];
  end

`ifdef RAM_PARITY_EN
  logic [BE_WIDE-1:0] par_mem [DEEP];
  logic [BE_WIDE-1:0] w_par, r_par;
  logic               r_err;

  always_comb begin
    w_par = '0;
    for (int i = 0; i < BE_WIDE; i++)
      w_par[i] = even_parity(w_data[i*BYTE_W +: BYTE_W]);
    w_par[0] = w_par[0] ^ (wr_err_inj & ~clr_we);
  end

  always_ff @(posedge clk) begin
    if (w_en)
      for (int i = 0; i < BE_WIDE; i++)
        if (w_be[i])
          par_mem[w_addr][i] <= w_par[i];
  end
`endif

  // Write-first merge: enabled lanes of a same-address write win.
  always_comb begin
    r_data = '0;
`ifdef RAM_PARITY_EN
    r_par = '0;
`endif
    if (rd_in) begin
      r_data = mem[rd_addr];
`ifdef RAM_PARITY_EN
      r_par = par_mem[rd_addr];
`endif
      for (int i = 0; i < BE_WIDE; i++)
        if (w_en && (w_addr == rd_addr) && w_be[i]) begin
          r_data[i*BYTE_W +: BYTE_W] = w_data[i*BYTE_W +: BYTE_W];
`ifdef RAM_PARITY_EN
          r_par[i] = w_par[i];
`endif
        end
    end
  end

`ifdef RAM_PARITY_EN
  always_comb begin
    r_err = 1'b0;
    for (int i = 0; i < BE_WIDE; i++)
      if (r_par[i] != even_parity(r_data[i*BYTE_W +: BYTE_W]))
        r_err = 1'b1;
  end
  assign p_in   = {r_err, r_data};
  assign rd_err = p_out[DATA_WIDE];
`else
  assign p_in = r_data;
`endif

  ram_rd_pipe #(
    .LAT (LAT),
    .W   (PW)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_fire),
    .in_data   (p_in),
    .out_valid (rd_data_valid),
    .out_data  (p_out)
  );

  assign rd_data = p_out[DATA_WIDE-1:0];

endmodule

// File: tb/tb_ram_sdp.sv
// Randomized bench for ram_sdp against a word/byte array model.
// DEEP=13 so out-of-range addresses 13..15 are reachable; RD_LAT=2.
module tb_ram_sdp;

  localparam int DW   = 32;
  localparam int DEEP = 13;
  localparam int AW   = 4;
  localparam int BW   = 4;
  localparam int LAT  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [BW-1:0] wr_be;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_data_valid, init_done;
  logic [DW-1:0] rd_data;
  logic          rd_err;
  logic          wr_err_inj;

  always #5 clk = ~clk;

  ram_sdp #(
    .DATA_WIDE    (DW),
    .DEEP         (DEEP),
    .ADDR_WIDE    (AW),
    .BE_WIDE      (BW),
    .RD_LAT       (LAT),
    .CLEAR_ON_RST (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_be         (wr_be),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_addr       (rd_addr),
    .rd_data_valid (rd_data_valid),
    .init_done     (init_done),
`ifdef RAM_PARITY_EN
    .rd_err        (rd_err),
    .wr_err_inj    (wr_err_inj),
`endif
    .rd_data       (rd_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t        pend[$];
  logic [31:0] model [DEEP];
  logic        bad   [DEEP];
  int          since;
  int          edge_n;
  logic [31:0] last_d;
  logic [BW-1:0] be_r;

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  task automatic cycle(input logic        wv,
                       input logic [3:0]  wa,
                       input logic [31:0] wd,
                       input logic [3:0]  wbe,
                       input logic        inj,
                       input logic        rv,
                       input logic [3:0]  ra);
    bit   rdy;
    exp_t x;
    wr_valid   = wv;
    wr_addr    = wa;
    wr_data    = wd;
    wr_be      = wbe;
    wr_err_inj = inj;
    rd_valid   = rv;
    rd_addr    = ra;
    rdy = (since >= DEEP + 1);
    if (rdy && rv) begin
      x.due = edge_n + LAT;
      x.d   = '0;
      x.e   = 1'b0;
      if (ra < DEEP) begin
        x.d = model[ra];
        x.e = bad[ra];
        if (wv && wa == ra) begin
          x.d = merge(x.d, wd, wbe);
          if (wbe[0]) x.e = inj;
        end
      end
      pend.push_back(x);
    end
    if (rdy && wv && wa < DEEP) begin
      model[wa] = merge(model[wa], wd, wbe);
      if (wbe[0]) bad[wa] = inj;
    end
    @(posedge clk);
    edge_n++;
    since++;
    @(negedge clk);
    check("init_done", init_done, since >= DEEP + 1);
    check("wr_ready", wr_ready, since >= DEEP + 1);
    check("rd_ready", rd_ready, since >= DEEP + 1);
    if (pend.size() > 0 && pend[0].due == edge_n) begin
      x = pend.pop_front();
      check("rd_valid", rd_data_valid, 1'b1);
      last_d = x.d;
`ifdef RAM_PARITY_EN
      check("rd_err", rd_err, x.e);
`endif
    end else begin
      check("rd_valid", rd_data_valid, 1'b0);
    end
    check("rd_data", rd_data, last_d);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    cycle(1, a, d, be, 0, 0, 0);
  endtask

  task automatic rd(input logic [3:0] a);
    cycle(0, 0, 0, 0, 0, 1, a);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    #1;
    check("rst_valid", rd_data_valid, 1'b0);
    check("rst_data", rd_data, 32'h0);
    check("rst_init", init_done, 1'b0);
    check("rst_wrdy", wr_ready, 1'b0);
    check("rst_rrdy", rd_ready, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_valid", rd_data_valid, 1'b0);
    end
    pend.delete();
    last_d = '0;
    since  = 0;
    for (int i = 0; i < DEEP; i++) begin
      model[i] = '0;
      bad[i]   = 1'b0;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    wr_valid = 0; wr_addr = 0; wr_data = 0; wr_be = 0;
    wr_err_inj = 0; rd_valid = 0; rd_addr = 0;
    edge_n = 0; since = 0; last_d = 0;
    @(negedge clk);
    do_reset();

    // Requests during the clear must be ignored.
    for (int i = 0; i < DEEP + 3; i++)
      cycle($urandom % 2, 4'($urandom), $urandom, 4'($urandom),
            0, $urandom % 2, 4'($urandom));

    for (int i = 0; i < 16; i++) rd(4'(i));
    repeat (LAT + 1) idle();

    wr(5, 32'hAABBCCDD, 4'hF);
    wr(5, 32'h11223344, 4'b0101);
    rd(5);
    idle();
    check("be_merge", rd_data, 32'hAA22CC44);

    wr(3, 32'hFFFFFFFF, 4'hF);
    cycle(1, 3, 32'h12345678, 4'b0011, 0, 1, 3);
    idle();
    check("collide", rd_data, 32'hFFFF5678);

    for (int i = 0; i < 8; i++) wr(4'(i), 32'hC0DE0000 + i, 4'hF);
    for (int i = 0; i < 8; i++) rd(4'(i));
    repeat (LAT + 1) idle();
    check("seq_last", rd_data, 32'hC0DE0007);

    wr(12, 32'h0BADF00D, 4'hF);
    wr(14, 32'hDEADBEEF, 4'hF);
    rd(12);
    idle();
    check("last_addr", rd_data, 32'h0BADF00D);
    rd(14);
    idle();
    check("oob_read", rd_data, 32'h0);

`ifdef RAM_PARITY_EN
    cycle(1, 7, 32'h1, 4'hF, 1, 0, 0);
    rd(7);
    idle();
    check("par_inj", {rd_err, rd_data}, {1'b1, 32'h1});
    wr(7, 32'h1, 4'hF);
    rd(7);
    idle();
    check("par_clean", rd_err, 1'b0);
`endif

    for (int i = 0; i < 400; i++) begin
      be_r = 4'($urandom);
`ifdef RAM_PARITY_EN
      cycle($urandom % 2, 4'($urandom), $urandom, be_r,
            1'($urandom % 4 == 0), $urandom % 2, 4'($urandom));
`else
      cycle($urandom % 2, 4'($urandom), $urandom, be_r,
            0, $urandom % 2, 4'($urandom));
`endif
    end
    repeat (LAT + 1) idle();

    // A read in flight when reset hits must never surface.
    rd(2);
    do_reset();
    for (int i = 0; i < DEEP + 4; i++) idle();
    for (int i = 0; i < DEEP; i++) rd(4'(i));
    repeat (LAT + 1) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
